// File: rtl/animated_sprite_blob_pkg.sv
// Shared types and helpers for the animated sprite overlay.
package sprite_pkg;

    typedef logic [23:0] rgb_t;

    localparam rgb_t RGB_BLACK = 24'h000000;

    // Linear ROM address of a sprite pixel: images are stored back to back,
    // each one row-major.
    function automatic int sprite_addr(input int frame, input int row, input int col,
                                       input int width, input int height);
        return frame * width * height + row * width + col;
    endfunction

endpackage

// File: rtl/animated_sprite_blob_if.sv
// Bus bundle of the sprite block: ROM read port, palette write port and
// the pixel output toward the display mux.
interface animated_sprite_blob_if #(
    parameter int ADDR_W = 15,
    parameter int BPP    = 2
);
    import sprite_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [BPP-1:0]    rom_data;
    logic              pal_we;
    logic [BPP-1:0]    pal_idx;
    rgb_t              pal_rgb;
    rgb_t              pixel;
    logic              pixel_valid;

    modport master (
        output rom_data, pal_we, pal_idx, pal_rgb,
        input  rom_addr, pixel, pixel_valid
    );

    modport slave (
        input  rom_data, pal_we, pal_idx, pal_rgb,
        output rom_addr, pixel, pixel_valid
    );

endinterface

// File: rtl/animated_sprite_blob_palette.sv
// 2^BPP-entry RGB palette: synchronous write, registered read. A read of
// the index being written in the same cycle returns the old colour.
module sprite_palette
    import sprite_pkg::*;
#(
    parameter int BPP = 2
) (
    input  logic           pixel_clk,
    input  logic           reset,
    input  logic           we,
    input  logic [BPP-1:0] wr_idx,
    input  rgb_t           wr_rgb,
    input  logic [BPP-1:0] rd_idx,
    output rgb_t           rd_rgb
);
    localparam int ENTRIES = 1 << BPP;

    rgb_t mem_q [ENTRIES];
    rgb_t mem_d [ENTRIES];
    rgb_t rd_q;
    rgb_t rd_d;

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            assign mem_d[gi] = (we && (wr_idx == BPP'(gi))) ? wr_rgb : mem_q[gi];
        end
    endgenerate

    // Lookup uses the pre-write contents of the table.
    always_comb begin
        rd_d = mem_q[rd_idx];
    end

    // Palette storage and read register; reset blanks every entry.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= RGB_BLACK;
            end
            rd_q <= RGB_BLACK;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem_q[i] <= mem_d[i];
            end
            rd_q <= rd_d;
        end
    end

    assign rd_rgb = rd_q;

endmodule

// File: rtl/animated_sprite_blob.sv
// Animated sprite overlay: hit test against a frame-latched position,
// ROM address generation, hit pipeline matched to the ROM latency and a
// palette lookup. Output lags hcount/vcount by ROM_LAT+2 cycles.
// Optional macro SPRITE_MIRROR_EN adds a frame-latched horizontal flip.
module animated_sprite_blob
    import sprite_pkg::*;
#(
    parameter int WIDTH           = 110,
    parameter int HEIGHT          = 59,
    parameter int FRAMES          = 4,
    parameter int BPP             = 2,
    parameter int ADDR_W          = 15,
    parameter int ROM_LAT         = 1,
    parameter int FRAME_HOLD      = 8,
    parameter int TRANSPARENT_IDX = 0
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        vsync,
    input  logic        anim_en,
`ifdef SPRITE_MIRROR_EN
    input  logic        mirror,
`endif
    animated_sprite_blob_if.slave bus
);
    localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int HOLD_W  = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    logic               vsync_prev_q, vsync_prev_d;
    logic               armed_q, armed_d;
    logic [10:0]        xl_q, xl_d;
    logic [9:0]         yl_q, yl_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ROM_LAT:0]   hit_q, hit_d;
    logic               valid_q, valid_d;
`ifdef SPRITE_MIRROR_EN
    logic               mirror_q, mirror_d;
`endif

    logic               vsync_rise;
    logic               hit;
    logic [11:0]        x_end;
    logic [10:0]        y_end;
    logic [10:0]        col_off;
    logic [10:0]        col;
    logic [9:0]         row;
    rgb_t               pal_rd;

    // Frame boundary: latch position (tear-free) and step the animation.
    always_comb begin
        vsync_rise   = vsync && !vsync_prev_q;
        vsync_prev_d = vsync;
        armed_d      = armed_q;
        xl_d         = xl_q;
        yl_d         = yl_q;
        frame_d      = frame_q;
        hold_d       = hold_q;
`ifdef SPRITE_MIRROR_EN
        mirror_d     = mirror_q;
`endif
        if (vsync_rise) begin
            armed_d = 1'b1;
            xl_d    = x;
            yl_d    = y;
`ifdef SPRITE_MIRROR_EN
            mirror_d = mirror;
`endif
            if (anim_en) begin
                if (hold_q == HOLD_W'(FRAME_HOLD - 1)) begin
                    hold_d  = '0;
                    frame_d = (frame_q == FRAME_W'(FRAMES - 1)) ? '0 : frame_q + 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
        end
    end

    // Hit test with one extra bit on the far edges so an overhanging
    // sprite clips at the raster edge instead of wrapping to column 0.
    always_comb begin
        x_end   = {1'b0, xl_q} + 12'(WIDTH);
        y_end   = {1'b0, yl_q} + 11'(HEIGHT);
        hit     = armed_q
                && (hcount >= xl_q) && ({1'b0, hcount} < x_end)
                && (vcount >= yl_q) && ({1'b0, vcount} < y_end);
        col_off = hcount - xl_q;
        row     = vcount - yl_q;
`ifdef SPRITE_MIRROR_EN
        col     = mirror_q ? (11'(WIDTH - 1) - col_off) : col_off;
`else
        col     = col_off;
`endif
        addr_d  = hit ? ADDR_W'(sprite_addr(32'(frame_q), 32'(row), 32'(col), WIDTH, HEIGHT))
                      : addr_q;
        valid_d = hit_q[ROM_LAT] && (bus.rom_data != BPP'(TRANSPARENT_IDX));
    end

    // Hit flag travels alongside the ROM request, one stage per cycle.
    generate
        for (genvar gi = 0; gi <= ROM_LAT; gi++) begin : g_hit_pipe
            if (gi == 0) begin : g_first
                assign hit_d[gi] = hit;
            end else begin : g_rest
                assign hit_d[gi] = hit_q[gi-1];
            end
        end
    endgenerate

    // State registers.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            vsync_prev_q <= 1'b0;
            armed_q      <= 1'b0;
            xl_q         <= '0;
            yl_q         <= '0;
            frame_q      <= '0;
            hold_q       <= '0;
            addr_q       <= '0;
            hit_q        <= '0;
            valid_q      <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            mirror_q     <= 1'b0;
`endif
        end else begin
            vsync_prev_q <= vsync_prev_d;
            armed_q      <= armed_d;
            xl_q         <= xl_d;
            yl_q         <= yl_d;
            frame_q      <= frame_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            hit_q        <= hit_d;
            valid_q      <= valid_d;
`ifdef SPRITE_MIRROR_EN
            mirror_q     <= mirror_d;
`endif
        end
    end

    sprite_palette #(.BPP(BPP)) u_palette (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .we        (bus.pal_we),
        .wr_idx    (bus.pal_idx),
        .wr_rgb    (bus.pal_rgb),
        .rd_idx    (bus.rom_data),
        .rd_rgb    (pal_rd)
    );

    assign bus.rom_addr    = addr_q;
    assign bus.pixel_valid = valid_q;
    assign bus.pixel       = valid_q ? pal_rd : RGB_BLACK;

endmodule

// File: tb/tb_animated_sprite_blob.sv
// Scoreboard bench for animated_sprite_blob (ROM_LAT=1, FRAME_HOLD=2).
// Stimulus pushes hand-computed expectations; a negedge monitor checks them.
module tb_animated_sprite_blob;

    logic        pixel_clk = 1'b0;
    logic        reset     = 1'b1;
    logic [10:0] x         = '0;
    logic [10:0] hcount    = '0;
    logic [9:0]  y         = '0;
    logic [9:0]  vcount    = '0;
    logic        vsync     = 1'b0;
    logic        anim_en   = 1'b0;
`ifdef SPRITE_MIRROR_EN
    logic        mirror    = 1'b0;
`endif

    animated_sprite_blob_if #(.ADDR_W(15), .BPP(2)) bus ();

    animated_sprite_blob #(.FRAME_HOLD(2)) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .hcount    (hcount),
        .vcount    (vcount),
        .vsync     (vsync),
        .anim_en   (anim_en),
`ifdef SPRITE_MIRROR_EN
        .mirror    (mirror),
`endif
        .bus       (bus)
    );

    always #5 pixel_clk = ~pixel_clk;

    int cyc = 0;
    always @(posedge pixel_clk) cyc <= cyc + 1;

    // Synchronous ROM with one cycle of latency.
    logic [1:0] rom_mem [0:32767];
    always @(posedge pixel_clk) bus.rom_data <= rom_mem[bus.rom_addr];

    typedef struct {
        int          due;
        logic [23:0] pix;
        logic        val;
        string       name;
    } pix_exp_t;

    typedef struct {
        int          due;
        logic [14:0] addr;
        string       name;
    } addr_exp_t;

    pix_exp_t  pix_q[$];
    addr_exp_t addr_q[$];
    int checks = 0;
    int passed = 0;

    task automatic exp_pix(input int lag, input logic [23:0] p, input logic v, input string nm);
        pix_exp_t e;
        e.due = cyc + lag; e.pix = p; e.val = v; e.name = nm;
        pix_q.push_back(e);
    endtask

    task automatic exp_addr(input int lag, input logic [14:0] a, input string nm);
        addr_exp_t e;
        e.due = cyc + lag; e.addr = a; e.name = nm;
        addr_q.push_back(e);
    endtask

    // One raster sample per cycle; the inputs set here are taken at the next edge.
    task automatic tick(input logic [10:0] h, input logic [9:0] v, input logic rst, input logic vs);
        @(posedge pixel_clk); #1;
        hcount = h; vcount = v; reset = rst; vsync = vs; bus.pal_we = 1'b0;
    endtask

    task automatic vs_pulse();
        tick(11'd0, 10'd0, 1'b0, 1'b1);
        tick(11'd0, 10'd0, 1'b0, 1'b0);
    endtask

    task automatic pal_write(input logic [1:0] idx, input logic [23:0] rgb);
        @(posedge pixel_clk); #1;
        hcount = '0; vcount = '0; reset = 1'b0; vsync = 1'b0;
        bus.pal_we = 1'b1; bus.pal_idx = idx; bus.pal_rgb = rgb;
    endtask

    // Monitor: compare every expectation whose due cycle has arrived.
    always @(negedge pixel_clk) begin
        pix_exp_t  pe;
        addr_exp_t ae;
        while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
            pe = pix_q.pop_front();
            checks++;
            if (pe.due == cyc && bus.pixel === pe.pix && bus.pixel_valid === pe.val) begin
                passed++;
                $display("check %s ok: pixel=%h valid=%b (cycle %0d)", pe.name, bus.pixel, bus.pixel_valid, cyc);
            end else begin
                $display("FAIL %s: pixel=%h valid=%b, required pixel=%h valid=%b (cycle %0d, due %0d)",
                         pe.name, bus.pixel, bus.pixel_valid, pe.pix, pe.val, cyc, pe.due);
            end
        end
        while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
            ae = addr_q.pop_front();
            checks++;
            if (ae.due == cyc && bus.rom_addr === ae.addr) begin
                passed++;
                $display("check %s ok: rom_addr=%0d (cycle %0d)", ae.name, bus.rom_addr, cyc);
            end else begin
                $display("FAIL %s: rom_addr=%0d, required %0d (cycle %0d, due %0d)",
                         ae.name, bus.rom_addr, ae.addr, cyc, ae.due);
            end
        end
    end

    int          anim_seq [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    logic [23:0] frame_rgb[4] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000};

    initial begin
        // ROM pattern: index = (addr % 3) + 1, with one transparent pixel at 5.
        for (int a = 0; a < 32768; a++) rom_mem[a] = 2'((a % 3) + 1);
        rom_mem[5] = 2'd0;
        bus.pal_we = 1'b0; bus.pal_idx = '0; bus.pal_rgb = '0;

        // Reset state.
        repeat (3) tick(11'd0, 10'd0, 1'b1, 1'b0);
        exp_pix(1, 24'h0, 1'b0, "reset_pixel");
        exp_addr(1, 15'd0, "reset_addr");

        // Box at (0,0) would cover this point, but nothing is drawn before vsync.
        tick(11'd100, 10'd50, 1'b0, 1'b0);
        exp_pix(3, 24'h0, 1'b0, "no_draw_pre_vsync");
        exp_addr(1, 15'd0, "addr_idle_pre_vsync");

        pal_write(2'd0, 24'h123456);
        pal_write(2'd1, 24'hFF0000);
        pal_write(2'd2, 24'h00FF00);
        pal_write(2'd3, 24'h0000FF);
        x = 11'd100; y = 10'd50;
        vs_pulse();

        tick(11'd100, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd0,    "origin_addr"); exp_pix(3, 24'hFF0000, 1'b1, "origin_pix");
        tick(11'd101, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd1,    "col1_addr");   exp_pix(3, 24'h00FF00, 1'b1, "col1_pix");
        tick(11'd102, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd2,    "col2_addr");   exp_pix(3, 24'h0000FF, 1'b1, "col2_pix");
        tick(11'd99,  10'd50, 1'b0, 1'b0); exp_addr(1, 15'd2,    "addr_hold");   exp_pix(3, 24'h0, 1'b0, "left_of_box");
        tick(11'd210, 10'd50, 1'b0, 1'b0);                                       exp_pix(3, 24'h0, 1'b0, "right_of_box");
        tick(11'd209, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd109,  "lastcol_addr"); exp_pix(3, 24'h00FF00, 1'b1, "lastcol_pix");
        tick(11'd100, 10'd51, 1'b0, 1'b0); exp_addr(1, 15'd110,  "row1_addr");   exp_pix(3, 24'h0000FF, 1'b1, "row1_pix");
        tick(11'd100, 10'd108, 1'b0, 1'b0); exp_addr(1, 15'd6380, "lastrow_addr"); exp_pix(3, 24'h0000FF, 1'b1, "lastrow_pix");
        tick(11'd100, 10'd109, 1'b0, 1'b0);                                      exp_pix(3, 24'h0, 1'b0, "below_box");
        tick(11'd100, 10'd49, 1'b0, 1'b0);                                       exp_pix(3, 24'h0, 1'b0, "above_box");
        tick(11'd105, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd5,    "transp_addr"); exp_pix(3, 24'h0, 1'b0, "transparent");

        // Animation: frame seen before each of nine vsync edges.
        anim_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick(11'd100, 10'd50, 1'b0, 1'b0);
            exp_addr(1, 15'(6490 * anim_seq[k]), "anim_addr");
            exp_pix(3, frame_rgb[anim_seq[k]], 1'b1, "anim_pix");
            vs_pulse();
        end
        vs_pulse();                       // now frame 1, hold 0
        anim_en = 1'b0;
        repeat (3) vs_pulse();
        tick(11'd100, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd6490, "frozen_addr"); exp_pix(3, 24'h00FF00, 1'b1, "frozen_pix");

        // Position change only applies at the next vsync edge.
        x = 11'd300;
        tick(11'd100, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd6490, "pos_old_addr"); exp_pix(3, 24'h00FF00, 1'b1, "pos_old_pix");
        tick(11'd300, 10'd50, 1'b0, 1'b0);                                         exp_pix(3, 24'h0, 1'b0, "pos_not_yet");
        vs_pulse();
        tick(11'd301, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd6491, "pos_new_addr"); exp_pix(3, 24'h0000FF, 1'b1, "pos_new_pix");
        tick(11'd100, 10'd50, 1'b0, 1'b0);                                         exp_pix(3, 24'h0, 1'b0, "pos_old_gone");

        // Right-edge clipping.
        x = 11'd2000;
        vs_pulse();
        tick(11'd2047, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd6537, "edge_addr");  exp_pix(3, 24'hFF0000, 1'b1, "edge_pix");
        tick(11'd2000, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd6490, "x2000_addr"); exp_pix(3, 24'h00FF00, 1'b1, "x2000_pix");
        tick(11'd0,    10'd50, 1'b0, 1'b0); exp_addr(1, 15'd6490, "nowrap_addr"); exp_pix(3, 24'h0, 1'b0, "nowrap_col0");
        tick(11'd1999, 10'd50, 1'b0, 1'b0);                                       exp_pix(3, 24'h0, 1'b0, "left_of_2000");
        tick(11'd47,   10'd50, 1'b0, 1'b0);                                       exp_pix(3, 24'h0, 1'b0, "nowrap_col47");

        // Reset in the middle of a drawn run.
        tick(11'd2000, 10'd50, 1'b0, 1'b0); exp_pix(3, 24'h00FF00, 1'b1, "pre_rst_pix");
        tick(11'd2001, 10'd50, 1'b0, 1'b0);
        tick(11'd2002, 10'd50, 1'b0, 1'b0);
        tick(11'd2003, 10'd50, 1'b1, 1'b0); exp_pix(1, 24'h0, 1'b0, "rst_mid_pix"); exp_addr(1, 15'd0, "rst_mid_addr");
        tick(11'd2000, 10'd50, 1'b0, 1'b0); exp_pix(3, 24'h0, 1'b0, "no_draw_after_rst"); exp_addr(1, 15'd0, "idle_after_rst");
        vs_pulse();
        // Frame back to 0, palette cleared: opaque pixel with black colour.
        tick(11'd2000, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd0, "frame0_addr"); exp_pix(3, 24'h0, 1'b1, "pal_cleared");

`ifdef SPRITE_MIRROR_EN
        mirror = 1'b1;
        vs_pulse();
        tick(11'd2000, 10'd50, 1'b0, 1'b0); exp_addr(1, 15'd109, "mirror_addr"); exp_pix(3, 24'h0, 1'b1, "mirror_pix");
`endif

        repeat (6) tick(11'd0, 10'd0, 1'b0, 1'b0);
        while (pix_q.size() > 0) begin
            checks++;
            $display("FAIL %s: pixel expectation never reached, due cycle %0d", pix_q[0].name, pix_q[0].due);
            void'(pix_q.pop_front());
        end
        while (addr_q.size() > 0) begin
            checks++;
            $display("FAIL %s: rom_addr expectation never reached, due cycle %0d", addr_q[0].name, addr_q[0].due);
            void'(addr_q.pop_front());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
